nt_msg_pad: RTL and testbench



---
 rtl/ntcrack_pkg.sv | 39 +++
 rtl/nt_utf16_packer.sv | 68 ++++++
 rtl/nt_msg_pad.sv | 211 +++++++++++++++++++++
 tb/tb_nt_msg_pad.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntcrack_pkg.sv
// Shared definitions for the NT-hash cracking datapath.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package ntcrack_pkg;

  // Longest password whose UTF-16LE form, pad byte and length field fit one MD4 block.
  localparam int MAX_CHARS = 27;

  // Byte offset of the little-endian 64-bit message length field.
  localparam int LEN_LO_BYTE = 56;

  // Cycles to wait out any md4block run left over from before reset (run is at most 55).
  localparam int GUARD_CYCLES = 64;

  // MD4 initial chaining values.
  localparam logic [31:0] MD4_IV_A = 32'h67452301;
  localparam logic [31:0] MD4_IV_B = 32'hEFCDAB89;
  localparam logic [31:0] MD4_IV_C = 32'h98BADCFE;
  localparam logic [31:0] MD4_IV_D = 32'h10325476;

  // Message terminator byte appended right after the last UTF-16 unit.
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_GUARD,
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN,
    ST_SKIP
  } pad_state_e;

  // MD4 words are little-endian; this gives the canonical digest byte order.
  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nt_utf16_packer.sv
// Byte-addressed 512-bit MD4 message buffer: UTF-16LE char write, finalize, clear.
// Latency: every operation lands in the buffer one cycle after it is requested.
// Backpressure: none; the caller sequences operations.
module nt_utf16_packer
  import ntcrack_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [4:0]   wr_idx,
  input  logic [7:0]   wr_char,
  input  logic         fin_en,
  input  logic [4:0]   fin_cnt,
  input  logic         clr,
  output logic [511:0] buf_dat
);

  logic [511:0] buf_q;
  logic [511:0] buf_d;
  logic [5:0]   char_byte;
  logic [5:0]   pad_byte;
  logic [15:0]  len_bits;

  // Char n occupies bytes 2n (ASCII) and 2n+1 (zero high byte); length is 16 bits per char.
  always_comb begin
    char_byte = {wr_idx, 1'b0};
    pad_byte  = {fin_cnt, 1'b0};
    len_bits  = {7'd0, fin_cnt, 4'd0};
  end

  // Next buffer contents: clear wins; a char write and finalize may share a cycle.
  always_comb begin
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (wr_en && (6'(k) == char_byte)) begin
          buf_d[511-8*k -: 8] = wr_char;
        end
        if (wr_en && (6'(k) == char_byte + 6'd1)) begin
          buf_d[511-8*k -: 8] = 8'h00;
        end
        if (fin_en && (6'(k) == pad_byte)) begin
          buf_d[511-8*k -: 8] = PAD_BYTE;
        end
        if (fin_en && (k == LEN_LO_BYTE)) begin
          buf_d[511-8*k -: 8] = len_bits[7:0];
        end
        if (fin_en && (k == LEN_LO_BYTE + 1)) begin
          buf_d[511-8*k -: 8] = len_bits[15:8];
        end
      end
    end
  end

  // Buffer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign buf_dat = buf_q;

endmodule

// File: rtl/nt_msg_pad.sv
// Builds one padded MD4 block from a password stream, runs md4block, returns the NT hash.
// Latency: last char at T -> md4_irdy T+1, hash_valid T+55, in_ready again T+56.
// Backpressure: in_ready low in GUARD/FIRE/WAIT/DRAIN; NT_MSG_PAD_TARGET_CMP_EN adds match compare.
module nt_msg_pad
  import ntcrack_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic         md4_irdy,
  output logic [511:0] md4_data,
  output logic [31:0]  md4_state_a,
  output logic [31:0]  md4_state_b,
  output logic [31:0]  md4_state_c,
  output logic [31:0]  md4_state_d,
  input  logic         md4_ordy,
  input  logic [31:0]  md4_new_a,
  input  logic [31:0]  md4_new_b,
  input  logic [31:0]  md4_new_c,
  input  logic [31:0]  md4_new_d,
  output logic         hash_valid,
  output logic [127:0] hash,
  output logic         overflow,
  input  logic [127:0] target,
  output logic         match
);

  localparam logic [4:0] MAX_N      = 5'(MAX_CHARS);
  localparam logic [5:0] GUARD_LAST = 6'(GUARD_CYCLES - 1);

  pad_state_e   state_q, state_d;
  logic [5:0]   guard_cnt_q, guard_cnt_d;
  logic [4:0]   n_q, n_d;
  logic [127:0] hash_q, hash_d;
  logic         hash_valid_q, hash_valid_d;
  logic         overflow_q, overflow_d;

  logic         wr_en;
  logic         fin_en;
  logic [4:0]   fin_cnt;
  logic         clr;
  logic [127:0] hash_next;

  assign md4_state_a = MD4_IV_A;
  assign md4_state_b = MD4_IV_B;
  assign md4_state_c = MD4_IV_C;
  assign md4_state_d = MD4_IV_D;

  assign hash_next = {byteswap32(md4_new_a), byteswap32(md4_new_b),
                      byteswap32(md4_new_c), byteswap32(md4_new_d)};

  nt_utf16_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (n_q),
    .wr_char (in_char),
    .fin_en  (fin_en),
    .fin_cnt (fin_cnt),
    .clr     (clr),
    .buf_dat (md4_data)
  );

  // Next-state, handshake and buffer-control decode; SKIP is the sticky drop state.
  always_comb begin
    state_d      = state_q;
    guard_cnt_d  = guard_cnt_q;
    n_d          = n_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    overflow_d   = 1'b0;
    wr_en        = 1'b0;
    fin_en       = 1'b0;
    fin_cnt      = n_q;
    clr          = 1'b0;
    in_ready     = 1'b0;
    md4_irdy     = 1'b0;

    case (state_q)
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 6'd1;
        end
      end

      ST_IDLE, ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last && in_empty) begin
            // Terminator only: the char lane carries nothing.
            fin_en  = 1'b1;
            fin_cnt = n_q;
            state_d = ST_FIRE;
          end else if (n_q == MAX_N) begin
            if (in_last) begin
              overflow_d = 1'b1;
              clr        = 1'b1;
              n_d        = '0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_SKIP;
            end
          end else begin
            wr_en = 1'b1;
            n_d   = n_q + 5'd1;
            if (in_last) begin
              fin_en  = 1'b1;
              fin_cnt = n_q + 5'd1;
              state_d = ST_FIRE;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end

      ST_FIRE: begin
        md4_irdy = 1'b1;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (md4_ordy) begin
          hash_d       = hash_next;
          hash_valid_d = 1'b1;
          state_d      = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!md4_ordy) begin
          clr     = 1'b1;
          n_d     = '0;
          state_d = ST_IDLE;
        end
      end

      ST_SKIP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          overflow_d = 1'b1;
          clr        = 1'b1;
          n_d        = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_GUARD;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_GUARD;
      guard_cnt_q  <= '0;
      n_q          <= '0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_cnt_q  <= guard_cnt_d;
      n_q          <= n_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign hash       = hash_q;
  assign hash_valid = hash_valid_q;
  assign overflow   = overflow_q;

`ifdef NT_MSG_PAD_TARGET_CMP_EN
  logic match_q, match_d;

  // Compare the incoming digest so match lines up with hash_valid.
  always_comb begin
    match_d = match_q;
    if ((state_q == ST_WAIT) && md4_ordy) begin
      match_d = (hash_next == target);
    end
  end

  // Match register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`else
  logic unused_target;
  assign unused_target = ^target;
  assign match         = 1'b0;
`endif

endmodule

// File: tb/tb_nt_msg_pad.sv
// Scoreboard bench for nt_msg_pad with a behavioural md4block stand-in.
// Latency: the stand-in raises ordy 53 cycles after it sees irdy.
// Backpressure: the bench holds in_valid until in_ready.
module tb_nt_msg_pad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_last, in_empty, in_ready;
  logic [7:0]   in_char;
  logic         md4_irdy, md4_ordy;
  logic [511:0] md4_data;
  logic [31:0]  md4_state_a, md4_state_b, md4_state_c, md4_state_d;
  logic [31:0]  md4_new_a, md4_new_b, md4_new_c, md4_new_d;
  logic         hash_valid, overflow, match;
  logic [127:0] hash, target;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [511:0] msg; int t; } irdy_exp_t;
  typedef struct { logic [127:0] h; int t; bit ovf; bit mt; } res_exp_t;
  irdy_exp_t irdy_q[$];
  res_exp_t  res_q[$];

  localparam logic [127:0] H_EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
  localparam logic [127:0] H_PASSW = 128'h8846f7eaee8fb117ad06bdd830b7586c;

  nt_msg_pad dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_empty(in_empty),
    .in_ready(in_ready),
    .md4_irdy(md4_irdy), .md4_data(md4_data),
    .md4_state_a(md4_state_a), .md4_state_b(md4_state_b),
    .md4_state_c(md4_state_c), .md4_state_d(md4_state_d),
    .md4_ordy(md4_ordy),
    .md4_new_a(md4_new_a), .md4_new_b(md4_new_b), .md4_new_c(md4_new_c), .md4_new_d(md4_new_d),
    .hash_valid(hash_valid), .hash(hash), .overflow(overflow),
    .target(target), .match(match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reference MD4 compression of one block from the standard IV; returns raw {a,b,c,d}.
  function automatic logic [127:0] md4_ref(input logic [511:0] m);
    logic [31:0] x [16];
    logic [31:0] a, b, c, d, f, t, add;
    int ord2 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int ord3 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int sh1 [4] = '{3, 7, 11, 19};
    int sh2 [4] = '{3, 5, 9, 13};
    int sh3 [4] = '{3, 9, 11, 15};
    int k, s;
    for (int i = 0; i < 16; i++)
      x[i] = {m[511-8*(4*i+3) -: 8], m[511-8*(4*i+2) -: 8], m[511-8*(4*i+1) -: 8], m[511-8*(4*i) -: 8]};
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476;
    for (int i = 0; i < 48; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d); k = i; s = sh1[i % 4]; add = 32'h0;
      end else if (i < 32) begin
        f = (b & c) | (b & d) | (c & d); k = ord2[i - 16]; s = sh2[i % 4]; add = 32'h5A827999;
      end else begin
        f = b ^ c ^ d; k = ord3[i - 32]; s = sh3[i % 4]; add = 32'h6ED9EBA1;
      end
      t = a + f + x[k] + add;
      t = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = t;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE, d + 32'h10325476};
  endfunction

  function automatic logic [127:0] canon(input logic [127:0] r);
    return {bswap(r[127:96]), bswap(r[95:64]), bswap(r[63:32]), bswap(r[31:0])};
  endfunction

  function automatic logic [511:0] build_msg(input string s, input int n);
    logic [511:0] m;
    logic [15:0]  len;
    m = '0;
    for (int i = 0; i < n; i++) m[511-16*i -: 8] = s[i];
    m[511-16*n -: 8] = 8'h80;
    len = 16'(16 * n);
    m[511-8*56 -: 8] = len[7:0];
    m[511-8*57 -: 8] = len[15:8];
    return m;
  endfunction

  function automatic bit exp_match(input logic [127:0] h);
`ifdef NT_MSG_PAD_TARGET_CMP_EN
    return (h == target);
`else
    return 1'b0;
`endif
  endfunction

  // md4block stand-in: capture at irdy, ordy pulse 53 cycles later with the digest.
  initial begin
    logic [511:0] cap;
    logic [127:0] st;
    md4_ordy = 1'b0;
    {md4_new_a, md4_new_b, md4_new_c, md4_new_d} = '0;
    forever begin
      @(negedge clk);
      if (md4_irdy === 1'b1) begin
        cap = md4_data;
        st  = md4_ref(cap);
        repeat (10) @(negedge clk);
        check_val("data_hold", md4_data, cap);
        repeat (43) @(negedge clk);
        md4_ordy = 1'b1;
        {md4_new_a, md4_new_b, md4_new_c, md4_new_d} = st;
        @(negedge clk);
        md4_ordy = 1'b0;
      end
    end
  end

  // Output monitor: pops scoreboard entries when the DUT produces irdy or a result.
  initial begin
    irdy_exp_t ie;
    res_exp_t  re;
    forever begin
      @(negedge clk);
      #1;
      if (md4_irdy === 1'b1) begin
        if (irdy_q.size() == 0) begin
          check_val("irdy_unexpected", 1, 0);
        end else begin
          ie = irdy_q.pop_front();
          check_val("irdy_time", cyc, ie.t + 1);
          check_val("md4_data", md4_data, ie.msg);
        end
      end
      if (hash_valid === 1'b1 || overflow === 1'b1) begin
        if (res_q.size() == 0) begin
          check_val("result_unexpected", {hash_valid, overflow}, 0);
        end else begin
          re = res_q.pop_front();
          check_val("result_kind", {hash_valid, overflow}, {~re.ovf, re.ovf});
          check_val("result_time", cyc, re.ovf ? re.t + 1 : re.t + 55);
          if (!re.ovf) begin
            check_val("hash", hash, re.h);
            check_val("match", match, re.mt);
          end
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; t is the accepting cycle.
  task automatic drive_beat(input logic [7:0] c, input bit last, input bit empty, output int t);
    int budget;
    in_valid = 1'b1; in_char = c; in_last = last; in_empty = empty;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) check_val("ready_timeout", 0, 1);
    t = cyc;
    @(negedge clk);
  endtask

  task automatic send_pw(input string s, input bit empty_pw, input bit known, input logic [127:0] kh,
                         input bit keep_valid, input bit want_result, output int t);
    int n;
    logic [511:0] m;
    logic [127:0] h;
    n = empty_pw ? 0 : s.len();
    if (empty_pw) drive_beat(8'h5A, 1'b1, 1'b1, t);
    else for (int i = 0; i < n; i++) drive_beat(s[i], (i == n - 1), 1'b0, t);
    if (!keep_valid) begin
      in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    end
    if (n > 27) begin
      res_q.push_back('{h: '0, t: t, ovf: 1'b1, mt: 1'b0});
      check_val("ovf_ready_back", in_ready, 1);
    end else begin
      m = build_msg(s, n);
      irdy_q.push_back('{msg: m, t: t});
      if (want_result) begin
        h = known ? kh : canon(md4_ref(m));
        res_q.push_back('{h: h, t: t, ovf: 1'b0, mt: exp_match(h)});
      end
    end
  endtask

  task automatic release_and_guard();
    int r;
    rst_n = 1'b1;
    r = cyc;
    while (cyc < r + 63) @(negedge clk);
    check_val("guard_ready_low", in_ready, 0);
    @(negedge clk);
    check_val("guard_ready_high", in_ready, 1);
  endtask

  initial begin
    int t, t2, wait_cnt;
    string s27, s28, s30;
    rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0; in_empty = 1'b0;
    target = H_PASSW;
    s27 = ""; s28 = ""; s30 = "";
    for (int i = 0; i < 27; i++) s27 = {s27, "a"};
    s28 = {s27, "a"};
    s30 = {s28, "aa"};

    repeat (3) @(negedge clk);
    check_val("rst_ready", in_ready, 0);
    check_val("rst_irdy", md4_irdy, 0);
    check_val("rst_hash_valid", hash_valid, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_match", match, 0);
    check_val("rst_hash", hash, 0);
    check_val("rst_data", md4_data, 0);
    check_val("iv", {md4_state_a, md4_state_b, md4_state_c, md4_state_d},
              128'h67452301EFCDAB8998BADCFE10325476);
    release_and_guard();

    check_val("empty_msg_const", build_msg("", 0), {8'h80, 504'h0});
    send_pw("", 1'b1, 1'b1, H_EMPTY, 1'b0, 1'b1, t);
    send_pw("password", 1'b0, 1'b1, H_PASSW, 1'b0, 1'b1, t);
    send_pw("Password", 1'b0, 1'b0, '0, 1'b0, 1'b1, t);
    send_pw(s27, 1'b0, 1'b0, '0, 1'b0, 1'b1, t);
    send_pw(s28, 1'b0, 1'b0, '0, 1'b0, 1'b0, t);
    send_pw(s30, 1'b0, 1'b0, '0, 1'b0, 1'b0, t);
    send_pw("ab", 1'b0, 1'b0, '0, 1'b0, 1'b1, t);

    send_pw("a", 1'b0, 1'b0, '0, 1'b1, 1'b1, t);
    send_pw("b", 1'b0, 1'b0, '0, 1'b0, 1'b1, t2);
    check_val("b2b_accept_gap", t2 - t, 56);

    send_pw("abc", 1'b0, 1'b0, '0, 1'b0, 1'b0, t);
    while (cyc < t + 20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("midrun_rst_hash", hash, 0);
    check_val("midrun_rst_irdy", md4_irdy, 0);
    release_and_guard();
    send_pw("password", 1'b0, 1'b1, H_PASSW, 1'b0, 1'b1, t);

    wait_cnt = 0;
    while ((irdy_q.size() != 0 || res_q.size() != 0) && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_val("scoreboard_drained", irdy_q.size() + res_q.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
